// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
//   Bundles the pipeline-control signals exchanged between pipe_ctrl and the
//   five pipeline stages.
//   master : the sequencer (pipe_ctrl). It receives the stall requests and the
//            committed exception, and drives stall/flush/redirect/watchdog.
//   slave  : the pipeline side. It drives the requests and exception, and
//            consumes the control outputs.
//   Signals:
//     stallreq_from_id/ex/mem  stage stall requests
//     excepttype_i[31:0]       committed exception type (0 = none)
//     cp0_epc_i[31:0]          forwarded EPC, used for ERET
//     stall[5:0]               bit0 PC .. bit5 WB, 1 = stop
//     flush                    clear all pipeline registers this cycle
//     new_pc[31:0]             redirect target, valid with flush
//     stall_timeout            sticky watchdog flag
//     stall_cycles[31:0]       stall performance counter (0 when not built)
interface pipe_ctrl_if;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  modport master (
    input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    input  excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    output stallreq_from_id, stallreq_from_ex, stallreq_from_mem,
    output excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, stall_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Central sequencer for the 5-stage core. Arbitrates stage stall requests
//   into the 6-bit stall vector, turns committed exceptions / ERET into a
//   flush plus redirect PC, holds a one-cycle post-flush recovery window and
//   runs a stall watchdog.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous, active-low reset
//     bus  pipe_ctrl_if.master (requests in, stall/flush/new_pc/watchdog out)
//   Parameters:
//     EXC_VECTOR  redirect PC for every non-ERET exception
//     WDOG_MAX    consecutive stalled cycles before stall_timeout is raised
//   Build option:
//     PIPE_CTRL_PERF_CNT_EN  when defined, builds the 32-bit stall_cycles
//                            counter; otherwise stall_cycles is tied to 0.
//
//   State          | meaning
//   ---------------+------------------------------------------------------
//   RUN            | normal stall arbitration and exception decode
//   FLUSH_RECOVER  | one cycle after a flush; all requests are ignored
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [15:0] WDOG_MAX   = 16'd1024
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.master      bus
);

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic {
    RUN           = 1'b0,
    FLUSH_RECOVER = 1'b1
  } state_t;

  state_t      state;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] new_pc_c;
  logic [15:0] wdog_cnt;
  logic [15:0] wdog_nxt;
  logic        timeout_q;

  // Outputs are combinational so the pipeline registers act on them in the
  // same cycle. Gating with rst makes them fall to zero as soon as reset is
  // asserted, without waiting for an edge.
  always_comb begin
    stall_c  = 6'b000000;
    flush_c  = 1'b0;
    new_pc_c = 32'h0;
    if (rst && state == RUN) begin
      if (bus.excepttype_i != 32'h0) begin
        flush_c  = 1'b1;
        new_pc_c = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
      end else if (bus.stallreq_from_mem) begin
        stall_c = 6'b011111;
      end else if (bus.stallreq_from_ex) begin
        stall_c = 6'b001111;
      end else if (bus.stallreq_from_id) begin
        stall_c = 6'b000111;
      end
    end
  end

  // Only RUN can raise flush, so leaving FLUSH_RECOVER always lands in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else if (flush_c) begin
      state <= FLUSH_RECOVER;
    end else begin
      state <= RUN;
    end
  end

  always_comb begin
    if (stall_c == 6'b000000 || flush_c) begin
      wdog_nxt = 16'd0;
    end else if (wdog_cnt >= WDOG_MAX) begin
      wdog_nxt = wdog_cnt;
    end else begin
      wdog_nxt = wdog_cnt + 16'd1;
    end
  end

  // The flag is set on the edge that completes the WDOG_MAX-th stalled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt  <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      wdog_cnt <= wdog_nxt;
      if (stall_c != 6'b000000 && wdog_nxt == WDOG_MAX) begin
        timeout_q <= 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Free-running, wraps at 2^32; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= 32'h0;
    end else if (stall_c[0]) begin
      perf_cnt <= perf_cnt + 32'h1;
    end
  end

  assign bus.stall_cycles = perf_cnt;
`else
  assign bus.stall_cycles = 32'h0;
`endif

  assign bus.stall         = stall_c;
  assign bus.flush         = flush_c;
  assign bus.new_pc        = new_pc_c;
  assign bus.stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Directed-vector bench for pipe_ctrl. Inputs change 1 ns after a rising
//   edge and outputs are checked 1 ns later, well away from the next edge.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic id, input logic ex, input logic mem);
    bus.stallreq_from_id  = id;
    bus.stallreq_from_ex  = ex;
    bus.stallreq_from_mem = mem;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    #1;
  endtask

  logic [31:0] exp_perf;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    set_req(1'b0, 1'b0, 1'b0);
    bus.excepttype_i = 32'h0;
    bus.cp0_epc_i    = 32'h0;
    #2;
    chk("rst_stall",   {26'h0, bus.stall}, 32'h0);
    chk("rst_flush",   {31'h0, bus.flush}, 32'h0);
    chk("rst_new_pc",  bus.new_pc, 32'h0);
    chk("rst_timeout", {31'h0, bus.stall_timeout}, 32'h0);
    chk("rst_cycles",  bus.stall_cycles, 32'h0);
    tick(2);
    rst = 1'b1;
    tick(1);

    // MEM stall, then asynchronous reset in the middle of it
    set_req(1'b0, 1'b0, 1'b1);
    #1;
    chk("mem_stall", {26'h0, bus.stall}, 32'h0000_001f);
    tick(1);
    rst = 1'b0;
    #1;
    chk("async_rst_stall", {26'h0, bus.stall}, 32'h0);
    chk("async_rst_flush", {31'h0, bus.flush}, 32'h0);
    tick(1);
    set_req(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("post_rst_stall", {26'h0, bus.stall}, 32'h0);
    chk("post_rst_flush", {31'h0, bus.flush}, 32'h0);
    tick(1);

    // ID request for exactly three cycles
    set_req(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("id_stall", {26'h0, bus.stall}, 32'h0000_0007);
      tick(1);
    end
    set_req(1'b0, 1'b0, 1'b0);
    #1;
    chk("id_release", {26'h0, bus.stall}, 32'h0);
    chk("id_timeout", {31'h0, bus.stall_timeout}, 32'h0);
    tick(1);

    // Priority: MEM > EX > ID
    set_req(1'b1, 1'b1, 1'b1);
    #1;
    chk("prio_all", {26'h0, bus.stall}, 32'h0000_001f);
    tick(1);
    set_req(1'b1, 1'b1, 1'b0);
    #1;
    chk("prio_ex_id", {26'h0, bus.stall}, 32'h0000_000f);
    tick(1);
    set_req(1'b1, 1'b0, 1'b0);
    #1;
    chk("prio_id", {26'h0, bus.stall}, 32'h0000_0007);
    tick(1);
    set_req(1'b0, 1'b0, 1'b0);

    // Exception beats a MEM stall; recovery ignores the still-held code
    set_req(1'b0, 1'b0, 1'b1);
    bus.excepttype_i = 32'h8;
    #1;
    chk("exc_flush",  {31'h0, bus.flush}, 32'h1);
    chk("exc_stall",  {26'h0, bus.stall}, 32'h0);
    chk("exc_new_pc", bus.new_pc, 32'h0000_0020);
    tick(1);
    chk("rec_flush",  {31'h0, bus.flush}, 32'h0);
    chk("rec_stall",  {26'h0, bus.stall}, 32'h0);
    chk("rec_new_pc", bus.new_pc, 32'h0);
    tick(1);
    bus.excepttype_i = 32'h0;
    #1;
    chk("resume_stall", {26'h0, bus.stall}, 32'h0000_001f);
    chk("resume_flush", {31'h0, bus.flush}, 32'h0);
    tick(1);
    set_req(1'b0, 1'b0, 1'b0);

    // ERET redirects to EPC
    bus.excepttype_i = 32'he;
    bus.cp0_epc_i    = 32'h0000_1234;
    #1;
    chk("eret_flush",  {31'h0, bus.flush}, 32'h1);
    chk("eret_new_pc", bus.new_pc, 32'h0000_1234);
    tick(1);
    bus.excepttype_i = 32'h0;
    tick(1);

    // Unknown nonzero code goes to the exception vector, not EPC
    bus.excepttype_i = 32'h3;
    #1;
    chk("unk_flush",  {31'h0, bus.flush}, 32'h1);
    chk("unk_new_pc", bus.new_pc, 32'h0000_0020);
    tick(1);
    bus.excepttype_i = 32'h0;
    bus.cp0_epc_i    = 32'h0;
    tick(1);

    // Watchdog clears when stall drops: 1000 + gap + 1000 never times out
    do_reset();
    set_req(1'b0, 1'b1, 1'b0);
    tick(1000);
    set_req(1'b0, 1'b0, 1'b0);
    tick(1);
    set_req(1'b0, 1'b1, 1'b0);
    tick(1000);
    chk("wdog_cleared", {31'h0, bus.stall_timeout}, 32'h0);
    set_req(1'b0, 1'b0, 1'b0);

    // Watchdog boundary at exactly WDOG_MAX stalled cycles
    do_reset();
    set_req(1'b0, 1'b1, 1'b0);
    tick(1023);
    chk("wdog_1023", {31'h0, bus.stall_timeout}, 32'h0);
    chk("wdog_stall_held", {26'h0, bus.stall}, 32'h0000_000f);
    tick(1);
    chk("wdog_1024", {31'h0, bus.stall_timeout}, 32'h1);
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp_perf = 32'd1024;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_cycles", bus.stall_cycles, exp_perf);
    set_req(1'b0, 1'b0, 1'b0);
    tick(3);
    chk("wdog_sticky", {31'h0, bus.stall_timeout}, 32'h1);
    bus.excepttype_i = 32'h1;
    tick(1);
    bus.excepttype_i = 32'h0;
    tick(1);
    chk("wdog_sticky_flush", {31'h0, bus.stall_timeout}, 32'h1);
    chk("perf_after_flush", bus.stall_cycles, exp_perf);
    rst = 1'b0;
    #1;
    chk("wdog_rst_clear", {31'h0, bus.stall_timeout}, 32'h0);
    chk("perf_rst_clear", bus.stall_cycles, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
